cache_refill_arbiter: RTL and testbench

- Shares the single main-memory port between the I-cache (fetch-miss refill) and the D-cache (victim writeback plus refill).
- Sits between both caches and the memory model. Caches raise hitF/hitM-driven stalls while their request is pending.
- Serves one block transfer at a time: round-robin grant, multi-beat bursts, one-cycle completion pulse per requester.

---
 rtl/cache_refill_arbiter_pkg.sv | 24 ++
 rtl/rr_pick.sv | 25 ++
 rtl/cache_refill_arbiter.sv | 174 +++++++++++++++++
 tb/tb_cache_refill_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_arbiter_pkg.sv
// Shared types for the cache refill arbiter: FSM state encoding, grant owners, block geometry.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cache_refill_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_IC_FILL = 3'd1,
      ST_DC_WB   = 3'd2,
      ST_DC_FILL = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int BLOCK_WORDS_DEF = 4;

   // Byte-offset width of one cache block (word index bits plus 2 byte bits).
   function automatic int blk_off_w(input int block_words);
      return $clog2(block_words) + 2;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin pick between the I-cache and D-cache requesters.
// Latency: purely combinational, decision valid in the same cycle as the requests.
// Backpressure: none; the caller only consumes the pick while idle.
module rr_pick
   import cache_refill_arbiter_pkg::*;
(
   input  logic req_i,
   input  logic req_d,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_owner
);

   // Under contention hand the grant to the side that did not win last time.
   always_comb begin
      grant_valid = req_i | req_d;
      grant_owner = OWN_I;
      if (req_i && req_d) begin
         grant_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
      end else if (req_d) begin
         grant_owner = OWN_D;
      end
   end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one memory port between I-cache refills and D-cache writeback+refill, one block at a time.
// Latency: grant one cycle after req in IDLE; each fill word appears the cycle after its mem_ack; done one cycle after last ack.
// Backpressure: beats hold address/data until mem_ack; requests arriving while busy wait for IDLE.
module cache_refill_arbiter
   import cache_refill_arbiter_pkg::*;
#(
   parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           ic_req,
   input  logic [ADDR_W-1:0]              ic_addr,
   input  logic                           dc_req,
   input  logic                           dc_wb,
   input  logic [ADDR_W-1:0]              dc_addr,
   input  logic [ADDR_W-1:0]              dc_wb_addr,
   input  logic [DATA_W-1:0]              dc_wdata,
   output logic [$clog2(BLOCK_WORDS)-1:0] wb_idx,
   output logic [DATA_W-1:0]              fill_data,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
   output logic                           ic_fill_valid,
   output logic                           dc_fill_valid,
   output logic                           ic_done,
   output logic                           dc_done,
   output logic                           mem_req,
   output logic                           mem_we,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_wdata,
   input  logic                           mem_ack,
   input  logic [DATA_W-1:0]              mem_rdata,
   output logic                           busy
);

   localparam int BEAT_W = $clog2(BLOCK_WORDS);
   localparam int OFF_W  = blk_off_w(BLOCK_WORDS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

   state_e              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                last_grant_q, last_grant_d;
   logic                owner_q, owner_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [DATA_W-1:0]   fill_data_q, fill_data_d;
   logic [BEAT_W-1:0]   fill_idx_q, fill_idx_d;
   logic                ic_fv_q, ic_fv_d;
   logic                dc_fv_q, dc_fv_d;
   logic                grant_valid, grant_owner;
   logic                beat_last, in_xfer;

   // Bursts always start at word 0 of the block, so drop the in-block offset.
   function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   endfunction

   rr_pick u_rr_pick (
      .req_i       (ic_req),
      .req_d       (dc_req),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   assign beat_last = (beat_q == LAST_BEAT);

   // State, beat counter, grant bookkeeping and the registered fill word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         beat_q       <= '0;
         last_grant_q <= OWN_I;
         owner_q      <= OWN_I;
         base_q       <= '0;
         fill_data_q  <= '0;
         fill_idx_q   <= '0;
         ic_fv_q      <= 1'b0;
         dc_fv_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         base_q       <= base_d;
         fill_data_q  <= fill_data_d;
         fill_idx_q   <= fill_idx_d;
         ic_fv_q      <= ic_fv_d;
         dc_fv_q      <= dc_fv_d;
      end
   end

   // Arbitrate in IDLE, step beats on mem_ack, capture fill words for one cycle.
   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      base_d       = base_q;
      fill_data_d  = fill_data_q;
      fill_idx_d   = fill_idx_q;
      ic_fv_d      = 1'b0;
      dc_fv_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            beat_d = '0;
            if (grant_valid) begin
               owner_d      = grant_owner;
               last_grant_d = grant_owner;
               if (grant_owner == OWN_I) begin
                  base_d  = blk_base(ic_addr);
                  state_d = ST_IC_FILL;
               end else if (dc_wb) begin
                  base_d  = blk_base(dc_wb_addr);
                  state_d = ST_DC_WB;
               end else begin
                  base_d  = blk_base(dc_addr);
                  state_d = ST_DC_FILL;
               end
            end
         end
         ST_DC_WB: begin
            if (mem_ack) begin
               if (beat_last) begin
                  // Victim is out; refill the missing block without an idle cycle.
                  beat_d  = '0;
                  base_d  = blk_base(dc_addr);
                  state_d = ST_DC_FILL;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         ST_IC_FILL, ST_DC_FILL: begin
            if (mem_ack) begin
               fill_data_d = mem_rdata;
               fill_idx_d  = beat_q;
               ic_fv_d     = (owner_q == OWN_I);
               dc_fv_d     = (owner_q == OWN_D);
               if (beat_last) begin
                  beat_d  = '0;
                  state_d = ST_DONE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Memory-side and requester-side outputs decoded from the current state.
   always_comb begin
      in_xfer  = (state_q == ST_IC_FILL) || (state_q == ST_DC_WB) || (state_q == ST_DC_FILL);
      mem_req  = in_xfer;
      mem_we   = (state_q == ST_DC_WB);
      mem_addr = in_xfer ? (base_q | (ADDR_W'(beat_q) << 2)) : '0;
      wb_idx   = (state_q == ST_DC_WB) ? beat_q : '0;
      ic_done  = (state_q == ST_DONE) && (owner_q == OWN_I);
      dc_done  = (state_q == ST_DONE) && (owner_q == OWN_D);
      busy     = (state_q != ST_IDLE);
   end

   assign mem_wdata     = dc_wdata;
   assign fill_data     = fill_data_q;
   assign fill_idx      = fill_idx_q;
   assign ic_fill_valid = ic_fv_q;
   assign dc_fill_valid = dc_fv_q;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Bench for cache_refill_arbiter: cache requesters and a memory model driven from tasks,
// transactions scored against an order/beat model built from the arbitration rules.
// Every scenario starts from a fresh reset so round-robin history is known.
module tb_cache_refill_arbiter;

   localparam int BW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ic_req, dc_req, dc_wb;
   logic [31:0] ic_addr, dc_addr, dc_wb_addr, dc_wdata;
   logic [1:0]  wb_idx, fill_idx;
   logic [31:0] fill_data, mem_addr, mem_wdata, mem_rdata;
   logic        ic_fill_valid, dc_fill_valid, ic_done, dc_done;
   logic        mem_req, mem_we, mem_ack, busy;

   always #5 clk = ~clk;

   cache_refill_arbiter #(.BLOCK_WORDS(BW), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .ic_req(ic_req), .ic_addr(ic_addr),
      .dc_req(dc_req), .dc_wb(dc_wb), .dc_addr(dc_addr), .dc_wb_addr(dc_wb_addr), .dc_wdata(dc_wdata),
      .wb_idx(wb_idx), .fill_data(fill_data), .fill_idx(fill_idx),
      .ic_fill_valid(ic_fill_valid), .dc_fill_valid(dc_fill_valid),
      .ic_done(ic_done), .dc_done(dc_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
   );

   typedef struct {
      logic busy, req, we, ack, icfv, dcfv, icd, dcd;
      logic [31:0] addr, wdata, fdata;
      logic [1:0] fidx, wbidx;
   } rec_t;
   typedef struct { logic own; logic wb; logic [31:0] addr; logic [31:0] wbaddr; } txn_t;
   typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } beat_t;
   typedef struct { logic own; logic [1:0] idx; logic [31:0] data; } fill_t;

   rec_t        lg[$];
   txn_t        iq[$], dq[$], ilist[$], dlist[$];
   beat_t       exp_beats[$];
   fill_t       exp_fills[$];
   logic        exp_done[$];
   logic [31:0] victim [BW];
   int          ack_pct, stall_cnt;
   logic [31:0] stall_addr;
   int          n_cmp = 0, n_bad = 0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_1F07;
   endfunction

   function automatic logic [31:0] blk(input logic [31:0] a);
      return a & ~32'(BW*4 - 1);
   endfunction

   task automatic drive_reqs();
      ic_req = (iq.size() > 0);
      if (iq.size() > 0) ic_addr = iq[0].addr; else ic_addr = $urandom;
      dc_req = (dq.size() > 0);
      if (dq.size() > 0) begin
         dc_wb = dq[0].wb; dc_addr = dq[0].addr; dc_wb_addr = dq[0].wbaddr;
      end else begin
         dc_wb = 1'($urandom); dc_addr = $urandom; dc_wb_addr = $urandom;
      end
   endtask

   // One clock: sample outputs, answer as caches and memory, log the cycle.
   task automatic step();
      rec_t r;
      @(posedge clk);
      #1;
      r.busy = busy; r.req = mem_req; r.we = mem_we; r.addr = mem_addr;
      r.icfv = ic_fill_valid; r.dcfv = dc_fill_valid; r.fidx = fill_idx; r.fdata = fill_data;
      r.icd = ic_done; r.dcd = dc_done; r.wbidx = wb_idx;
      if (ic_done && iq.size() > 0) iq.delete(0);
      if (dc_done && dq.size() > 0) dq.delete(0);
      drive_reqs();
      dc_wdata = victim[wb_idx];
      r.ack = 1'b0;
      if (mem_req) begin
         if (stall_cnt > 0 && mem_addr == stall_addr) stall_cnt--;
         else if (int'($urandom_range(99)) < ack_pct) r.ack = 1'b1;
      end
      mem_ack = r.ack;
      if (r.ack) mem_rdata = memfn(mem_addr); else mem_rdata = $urandom;
      #1;
      r.wdata = mem_wdata;
      lg.push_back(r);
   endtask

   task automatic run(input int max, output logic to);
      int n = 0;
      drive_reqs();
      do begin
         step();
         n++;
      end while ((iq.size() > 0 || dq.size() > 0 || busy) && n < max);
      to = (n >= max);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      iq.delete(); dq.delete(); lg.delete();
      ack_pct = 100; stall_cnt = 0; stall_addr = '0;
      for (int k = 0; k < BW; k++) victim[k] = $urandom;
      drive_reqs();
      mem_ack = 1'b0; mem_rdata = '0; dc_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reference: service order by round-robin over pending lists, then beats/fills per block.
   task automatic build_model();
      int a = 0, b = 0;
      logic last = 1'b0;
      logic pick_d;
      txn_t t;
      exp_beats.delete(); exp_fills.delete(); exp_done.delete();
      while (a < ilist.size() || b < dlist.size()) begin
         if (a < ilist.size() && b < dlist.size()) pick_d = ~last;
         else pick_d = (b < dlist.size());
         if (pick_d) begin t = dlist[b]; b++; end else begin t = ilist[a]; a++; end
         last = pick_d;
         if (pick_d && t.wb)
            for (int k = 0; k < BW; k++)
               exp_beats.push_back('{addr: blk(t.wbaddr) + 32'(4*k), we: 1'b1, wdata: victim[k]});
         for (int k = 0; k < BW; k++) begin
            exp_beats.push_back('{addr: blk(t.addr) + 32'(4*k), we: 1'b0, wdata: 32'h0});
            exp_fills.push_back('{own: pick_d, idx: 2'(k), data: memfn(blk(t.addr) + 32'(4*k))});
         end
         exp_done.push_back(pick_d);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ic_req = 0; dc_req = 0; dc_wb = 0; mem_ack = 0;
      ic_addr = '0; dc_addr = '0; dc_wb_addr = '0; dc_wdata = '0; mem_rdata = '0;
      #3;
      n_cmp++;
      if ({mem_req, mem_we, busy, ic_fill_valid, dc_fill_valid, ic_done, dc_done} !== 7'b0) begin
         n_bad++; $display("FAIL reset_ctrl got %b required 0000000", {mem_req, mem_we, busy, ic_fill_valid, dc_fill_valid, ic_done, dc_done});
      end
      n_cmp++;
      if (fill_data !== 32'h0 || fill_idx !== 2'd0 || wb_idx !== 2'd0) begin
         n_bad++; $display("FAIL reset_data got fill_data=%h fill_idx=%0d wb_idx=%0d required 0/0/0", fill_data, fill_idx, wb_idx);
      end
      do_reset();
      repeat (3) step();
      n_cmp++;
      if (lg[0].req !== 1'b0 || lg[1].busy !== 1'b0 || lg[2].req !== 1'b0) begin
         n_bad++; $display("FAIL reset_idle got req=%b busy=%b req=%b required 0", lg[0].req, lg[1].busy, lg[2].req);
      end
   endtask

   task automatic test_i_fill();
      logic to;
      int k = 0, nb = 0, nfv = 0, nd = 0, lastfv = -1, done_at = -1;
      do_reset();
      iq.push_back('{own: 1'b0, wb: 1'b0, addr: 32'h0040_0014, wbaddr: 32'h0});
      run(50, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL i_fill_timeout got no completion required ic_done"); end
      foreach (lg[i]) begin
         if (lg[i].busy) nb++;
         if (lg[i].req && lg[i].ack) begin
            n_cmp++;
            if (lg[i].addr !== 32'h0040_0010 + 32'(4*k) || lg[i].we !== 1'b0) begin
               n_bad++; $display("FAIL i_fill_beat%0d got addr=%h we=%b required addr=%h we=0", k, lg[i].addr, lg[i].we, 32'h0040_0010 + 32'(4*k));
            end
            k++;
         end
         if (lg[i].icfv) begin
            n_cmp++;
            if (lg[i].fidx !== 2'(nfv) || lg[i].fdata !== memfn(32'h0040_0010 + 32'(4*nfv))) begin
               n_bad++; $display("FAIL i_fill_word%0d got idx=%0d data=%h required idx=%0d data=%h", nfv, lg[i].fidx, lg[i].fdata, nfv, memfn(32'h0040_0010 + 32'(4*nfv)));
            end
            nfv++; lastfv = i;
         end
         if (lg[i].icd) begin nd++; done_at = i; end
      end
      n_cmp++; if (k !== 4 || nfv !== 4) begin n_bad++; $display("FAIL i_fill_counts got beats=%0d fills=%0d required 4/4", k, nfv); end
      n_cmp++; if (nd !== 1 || done_at !== lastfv) begin n_bad++; $display("FAIL i_fill_done got count=%0d at=%0d required 1 at=%0d", nd, done_at, lastfv); end
      n_cmp++; if (nb !== 5) begin n_bad++; $display("FAIL i_fill_busy got %0d cycles required 5", nb); end
   endtask

   task automatic test_d_wb();
      logic to;
      logic [31:0] ea;
      int k = 0, nfv = 0, nd = 0, nid = 0;
      do_reset();
      dq.push_back('{own: 1'b1, wb: 1'b1, addr: 32'h1000_0044, wbaddr: 32'h1000_0020});
      run(60, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL d_wb_timeout got no completion required dc_done"); end
      foreach (lg[i]) begin
         if (lg[i].req && lg[i].ack) begin
            ea = (k < 4) ? 32'h1000_0020 + 32'(4*k) : 32'h1000_0040 + 32'(4*(k-4));
            n_cmp++;
            if (lg[i].addr !== ea || lg[i].we !== (k < 4)) begin
               n_bad++; $display("FAIL d_wb_beat%0d got addr=%h we=%b required addr=%h we=%b", k, lg[i].addr, lg[i].we, ea, k < 4);
            end
            if (k < 4) begin
               n_cmp++;
               if (lg[i].wbidx !== 2'(k) || lg[i].wdata !== victim[k]) begin
                  n_bad++; $display("FAIL d_wb_data%0d got wb_idx=%0d wdata=%h required %0d/%h", k, lg[i].wbidx, lg[i].wdata, k, victim[k]);
               end
            end
            k++;
         end
         if (lg[i].dcfv) begin
            n_cmp++;
            if (lg[i].fidx !== 2'(nfv) || lg[i].fdata !== memfn(32'h1000_0040 + 32'(4*nfv))) begin
               n_bad++; $display("FAIL d_wb_fill%0d got idx=%0d data=%h required %0d/%h", nfv, lg[i].fidx, lg[i].fdata, nfv, memfn(32'h1000_0040 + 32'(4*nfv)));
            end
            nfv++;
         end
         if (lg[i].dcd) nd++;
         if (lg[i].icd || lg[i].icfv) nid++;
      end
      n_cmp++; if (k !== 8 || nfv !== 4 || nd !== 1 || nid !== 0) begin
         n_bad++; $display("FAIL d_wb_counts got beats=%0d fills=%0d dc_done=%0d i_events=%0d required 8/4/1/0", k, nfv, nd, nid);
      end
   endtask

   task automatic test_both();
      logic to;
      logic [31:0] ia;
      int dd = -1, id = -1, bad_pre = 0, bad_post = 0;
      do_reset();
      ia = 32'h0040_0000 | ($urandom & 32'h000F_FFFC);
      iq.push_back('{own: 1'b0, wb: 1'b0, addr: ia, wbaddr: 32'h0});
      dq.push_back('{own: 1'b1, wb: 1'($urandom), addr: 32'h1000_0000 | ($urandom & 32'h00FF_FFFC),
                     wbaddr: 32'h1100_0000 | ($urandom & 32'h00FF_FFFC)});
      run(100, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL both_timeout got no completion required two dones"); end
      foreach (lg[i]) begin
         if (lg[i].dcd && dd < 0) dd = i;
         if (lg[i].icd && id < 0) id = i;
      end
      n_cmp++; if (dd < 0 || id <= dd) begin n_bad++; $display("FAIL both_order got dc_done@%0d ic_done@%0d required D before I", dd, id); end
      if (dd >= 0 && dd + 2 < lg.size()) begin
         n_cmp++;
         if (lg[dd+1].req !== 1'b0 || lg[dd+2].req !== 1'b1 || lg[dd+2].addr !== blk(ia)) begin
            n_bad++; $display("FAIL both_gap got req=%b,%b addr=%h required 0,1 addr=%h", lg[dd+1].req, lg[dd+2].req, lg[dd+2].addr, blk(ia));
         end
         foreach (lg[i]) begin
            if (lg[i].req && i < dd && lg[i].addr[28] !== 1'b1) bad_pre++;
            if (lg[i].req && i > dd && lg[i].addr[28] !== 1'b0) bad_post++;
         end
         n_cmp++; if (bad_pre != 0 || bad_post != 0) begin n_bad++; $display("FAIL both_interleave got %0d/%0d foreign beats required 0/0", bad_pre, bad_post); end
      end
   endtask

   task automatic test_stall();
      logic to;
      logic [31:0] ia;
      int nhold = 0, nwait = 0, nwe = 0, nfv = 0, orphan = 0;
      logic [31:0] d2 = '0;
      do_reset();
      ia = 32'h0040_0000 | ($urandom & 32'h000F_FFFC);
      stall_addr = blk(ia) + 32'd8; stall_cnt = 5;
      iq.push_back('{own: 1'b0, wb: 1'b0, addr: ia, wbaddr: 32'h0});
      run(60, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL stall_timeout got no completion required ic_done"); end
      foreach (lg[i]) begin
         if (lg[i].req && lg[i].addr == stall_addr) begin
            nhold++;
            if (!lg[i].ack) nwait++;
            if (lg[i].we !== 1'b0) nwe++;
         end
         if (lg[i].icfv) begin
            nfv++;
            if (i == 0 || !lg[i-1].ack) orphan++;
            if (lg[i].fidx == 2'd2) d2 = lg[i].fdata;
         end
      end
      n_cmp++; if (nhold !== 6 || nwait !== 5) begin n_bad++; $display("FAIL stall_hold got held=%0d unacked=%0d required 6/5", nhold, nwait); end
      n_cmp++; if (nwe !== 0) begin n_bad++; $display("FAIL stall_we got %0d write cycles required 0", nwe); end
      n_cmp++; if (nfv !== 4 || orphan !== 0) begin n_bad++; $display("FAIL stall_valid got fills=%0d unacked_fills=%0d required 4/0", nfv, orphan); end
      n_cmp++; if (d2 !== memfn(stall_addr)) begin n_bad++; $display("FAIL stall_data got %h required %h", d2, memfn(stall_addr)); end
   endtask

   task automatic test_async_reset();
      logic to, hit = 1'b0;
      logic [31:0] da;
      int n = 0, k = 0, nfv = 0, nd = 0;
      logic [31:0] first = '0;
      do_reset();
      da = 32'h1000_0000 | ($urandom & 32'h00FF_FFFC);
      dq.push_back('{own: 1'b1, wb: 1'b0, addr: da, wbaddr: 32'h0});
      drive_reqs();
      while (!hit && n < 30) begin
         step(); n++;
         hit = lg[$].req && !lg[$].we && lg[$].addr == blk(da) + 32'd4;
      end
      n_cmp++; if (!hit) begin n_bad++; $display("FAIL areset_reach got no beat1 required beat1 at %h", blk(da) + 32'd4); end
      if (hit) begin
         n_cmp++; if (lg[$].dcfv !== 1'b1) begin n_bad++; $display("FAIL areset_pre got dc_fill_valid=%b required 1", lg[$].dcfv); end
         #2 rst = 1'b1;
         #1;
         n_cmp++;
         if ({mem_req, mem_we, busy, ic_fill_valid, dc_fill_valid, ic_done, dc_done} !== 7'b0) begin
            n_bad++; $display("FAIL areset_ctrl got %b required 0000000", {mem_req, mem_we, busy, ic_fill_valid, dc_fill_valid, ic_done, dc_done});
         end
         n_cmp++;
         if (fill_data !== 32'h0 || fill_idx !== 2'd0 || wb_idx !== 2'd0) begin
            n_bad++; $display("FAIL areset_data got %h/%0d/%0d required 0/0/0", fill_data, fill_idx, wb_idx);
         end
         @(posedge clk);
         @(negedge clk);
         rst = 1'b0;
         lg.delete();
         run(40, to);
         n_cmp++; if (to) begin n_bad++; $display("FAIL areset_timeout got no completion required dc_done"); end
         foreach (lg[i]) begin
            if (lg[i].req && lg[i].ack) begin
               if (k == 0) first = lg[i].addr;
               k++;
            end
            if (lg[i].dcfv) begin
               if (lg[i].fidx !== 2'(nfv) || lg[i].fdata !== memfn(blk(da) + 32'(4*nfv))) nd += 100;
               nfv++;
            end
            if (lg[i].dcd) nd++;
         end
         n_cmp++; if (first !== blk(da) || k !== 4) begin n_bad++; $display("FAIL areset_restart got first=%h beats=%0d required %h/4", first, k, blk(da)); end
         n_cmp++; if (nfv !== 4 || nd !== 1) begin n_bad++; $display("FAIL areset_fill got fills=%0d done_score=%0d required 4/1", nfv, nd); end
      end
   endtask

   task automatic test_back_to_back();
      logic to;
      int di = 0, dlo = 0;
      do_reset();
      ilist.delete(); dlist.delete();
      ilist.push_back('{own: 1'b0, wb: 1'b0, addr: 32'h0040_0000 | ($urandom & 32'h000F_FFFC), wbaddr: 32'h0});
      for (int t = 0; t < 3; t++)
         dlist.push_back('{own: 1'b1, wb: 1'($urandom), addr: 32'h1000_0000 | ($urandom & 32'h00FF_FFFC),
                           wbaddr: 32'h1100_0000 | ($urandom & 32'h00FF_FFFC)});
      build_model();
      iq = ilist; dq = dlist;
      run(300, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL b2b_timeout got no completion required 4 dones"); end
      foreach (lg[i]) begin
         if (lg[i].icd || lg[i].dcd) begin
            n_cmp++;
            if (di >= exp_done.size() || lg[i].dcd !== exp_done[di] || lg[i].icd === lg[i].dcd) begin
               n_bad++; $display("FAIL b2b_done%0d got ic=%b dc=%b required owner_d=%b", di, lg[i].icd, lg[i].dcd, (di < exp_done.size()) ? exp_done[di] : 1'bx);
            end
            di++;
         end
         if (lg[i].dcd && !lg[i].icd) dlo++;
      end
      n_cmp++; if (di !== 4 || dlo !== 3) begin n_bad++; $display("FAIL b2b_count got dones=%0d d=%0d required 4/3", di, dlo); end
   endtask

   task automatic test_random();
      logic to;
      int bi, fi, di;
      for (int it = 0; it < 6; it++) begin
         do_reset();
         ack_pct = int'($urandom_range(30, 100));
         ilist.delete(); dlist.delete();
         for (int t = 0; t < int'($urandom_range(0, 3)); t++)
            ilist.push_back('{own: 1'b0, wb: 1'b0, addr: 32'h0040_0000 | ($urandom & 32'h000F_FFFF), wbaddr: 32'h0});
         for (int t = 0; t < int'($urandom_range(1, 3)); t++)
            dlist.push_back('{own: 1'b1, wb: 1'($urandom), addr: 32'h1000_0000 | ($urandom & 32'h00FF_FFFF),
                              wbaddr: 32'h1100_0000 | ($urandom & 32'h00FF_FFFF)});
         build_model();
         iq = ilist; dq = dlist;
         run(3000, to);
         n_cmp++; if (to) begin n_bad++; $display("FAIL rand%0d_timeout got no completion required all dones", it); end
         bi = 0; fi = 0; di = 0;
         foreach (lg[i]) begin
            if (lg[i].req && lg[i].ack) begin
               n_cmp++;
               if (bi >= exp_beats.size()) begin
                  n_bad++; $display("FAIL rand%0d_beat%0d got extra addr=%h required none", it, bi, lg[i].addr);
               end else if (lg[i].addr !== exp_beats[bi].addr || lg[i].we !== exp_beats[bi].we ||
                            (exp_beats[bi].we && lg[i].wdata !== exp_beats[bi].wdata)) begin
                  n_bad++; $display("FAIL rand%0d_beat%0d got addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                                    it, bi, lg[i].addr, lg[i].we, lg[i].wdata, exp_beats[bi].addr, exp_beats[bi].we, exp_beats[bi].wdata);
               end
               bi++;
            end
            if (lg[i].icfv || lg[i].dcfv) begin
               n_cmp++;
               if (fi >= exp_fills.size()) begin
                  n_bad++; $display("FAIL rand%0d_fill%0d got extra idx=%0d required none", it, fi, lg[i].fidx);
               end else if (lg[i].icfv === lg[i].dcfv || lg[i].dcfv !== exp_fills[fi].own ||
                            lg[i].fidx !== exp_fills[fi].idx || lg[i].fdata !== exp_fills[fi].data) begin
                  n_bad++; $display("FAIL rand%0d_fill%0d got i=%b d=%b idx=%0d data=%h required own_d=%b idx=%0d data=%h",
                                    it, fi, lg[i].icfv, lg[i].dcfv, lg[i].fidx, lg[i].fdata, exp_fills[fi].own, exp_fills[fi].idx, exp_fills[fi].data);
               end
               fi++;
            end
            if (lg[i].icd || lg[i].dcd) begin
               n_cmp++;
               if (di >= exp_done.size() || lg[i].icd === lg[i].dcd || lg[i].dcd !== exp_done[di] ||
                   (lg[i].dcd ? lg[i].dcfv : lg[i].icfv) !== 1'b1 || lg[i].fidx !== 2'(BW-1)) begin
                  n_bad++; $display("FAIL rand%0d_done%0d got ic=%b dc=%b fv=%b%b idx=%0d required owner_d=%b with last fill",
                                    it, di, lg[i].icd, lg[i].dcd, lg[i].icfv, lg[i].dcfv, lg[i].fidx, (di < exp_done.size()) ? exp_done[di] : 1'bx);
               end
               di++;
            end
         end
         n_cmp++;
         if (bi !== exp_beats.size() || fi !== exp_fills.size() || di !== exp_done.size()) begin
            n_bad++; $display("FAIL rand%0d_counts got %0d/%0d/%0d required %0d/%0d/%0d", it, bi, fi, di, exp_beats.size(), exp_fills.size(), exp_done.size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_i_fill();
      test_d_wb();
      test_both();
      test_stall();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
